// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// The sequencer and the datapath both use these definitions.
package multdiv_sequencer_pkg;

  localparam int MULTDIV_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_sequencer_step_counter.sv
// Iteration counter for the multdiv sequencer.
// The synchronous clear takes priority over the enable. The terminal flag is high when the count is CYCLES-1.
module multdiv_sequencer_step_counter #(
  parameter int CYCLES = 32,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  logic [CNT_W-1:0] count_r;

  // iteration count register; holds when neither cleared nor enabled
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign term  = (count_r == CNT_W'(CYCLES - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Load/step sequencer for the shared multdiv datapath. Every output is a register.
// Each register is loaded from the next-state decode, so no input reaches an output without passing through a flop.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int CYCLES = MULTDIV_CYCLES,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             div_by_zero,
  output logic             load,
  output logic             step_en,
  output logic             op_div,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             result_rdy,
  output logic             exception
);

  state_t state_r;
  state_t state_nxt_s;
  logic   start_s;
  logic   cnt_clr_s;
  logic   cnt_en_s;
  logic   term_s;
  logic   load_r;
  logic   step_en_r;
  logic   op_div_r;
  logic   busy_r;
  logic   result_rdy_r;
  logic   exception_r;

  assign start_s = ctrl_mult | ctrl_div;

  // next-state logic; a start pulse in any state aborts the current operation
  always_comb begin
    state_nxt_s = state_r;
    if (start_s) begin
      state_nxt_s = LOAD;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = IDLE;
        LOAD:    state_nxt_s = (op_div_r && div_by_zero) ? DONE : RUN;
        RUN:     state_nxt_s = term_s ? DONE : RUN;
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  assign cnt_clr_s = (state_r == LOAD) && (state_nxt_s == RUN);
  assign cnt_en_s  = (state_r == RUN) && (state_nxt_s == RUN);

  // state register and output flops
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r      <= IDLE;
      load_r       <= 1'b0;
      step_en_r    <= 1'b0;
      busy_r       <= 1'b0;
      result_rdy_r <= 1'b0;
      exception_r  <= 1'b0;
      op_div_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      load_r       <= (state_nxt_s == LOAD);
      step_en_r    <= (state_nxt_s == RUN);
      busy_r       <= (state_nxt_s == LOAD) || (state_nxt_s == RUN);
      result_rdy_r <= (state_nxt_s == DONE);
      // DONE is reached straight from LOAD only on a divide by zero
      exception_r  <= (state_nxt_s == DONE) && (state_r == LOAD);
      if (start_s) begin
        op_div_r <= ctrl_div & ~ctrl_mult;
      end else begin
        op_div_r <= op_div_r;
      end
    end
  end

  multdiv_sequencer_step_counter #(
    .CYCLES (CYCLES),
    .CNT_W  (CNT_W)
  ) u_step_counter (
    .clk   (clk),
    .clr_n (clr_n),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .count (count),
    .term  (term_s)
  );

  assign load       = load_r;
  assign step_en    = step_en_r;
  assign op_div     = op_div_r;
  assign busy       = busy_r;
  assign result_rdy = result_rdy_r;
  assign exception  = exception_r;

endmodule
